text_lcd_writer: RTL

Drives a 2×16 HD44780-compatible character LCD in 8-bit, write-only mode for the digital clock display. After power-up it runs the controller's init sequence, then refreshes both lines continuously. Each refresh requests one character position at a time over `char_idx` and writes the returned ASCII byte to the panel. Upstream, the time/date registers and the BCD-digit-to-ASCII decoders feed `char_data` through a position multiplexer, with blank positions returning 0x20.

---
 rtl/text_lcd_writer.sv | 90 +++++++++
 1 files changed

// File: rtl/text_lcd_writer.sv
// text_lcd_writer: HD44780 2x16 LCD init + continuous refresh; ports: clk, rst_n, char_data in / char_idx, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done out
module text_lcd_writer #(
  parameter int TICK_DIV    = 2500,
  parameter int POWER_TICKS = 400,
  parameter int CLEAR_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_data,
  output logic [4:0] char_idx,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);
  localparam logic [3:0] POWER_WAIT = 4'd0, FUNC_SET = 4'd1, DISP_ON = 4'd2, ENTRY_MODE = 4'd3,
    CLEAR = 4'd4, CLEAR_WAIT = 4'd5, LINE1_ADDR = 4'd6, LINE1_DATA = 4'd7, LINE2_ADDR = 4'd8,
    LINE2_DATA = 4'd9;
  logic [15:0] div, cnt;
  logic [3:0] state, nxt;
  logic [1:0] phase;
  logic [7:0] cmd;
  logic tick, is_data;
  assign tick = div == 16'(TICK_DIV - 1);
  assign lcd_rw = 1'b0;
  always_comb begin
    is_data = state == LINE1_DATA || state == LINE2_DATA;
    cmd = state == FUNC_SET   ? 8'h38 :
          state == DISP_ON    ? 8'h0C :
          state == ENTRY_MODE ? 8'h06 :
          state == CLEAR      ? 8'h01 :
          state == LINE1_ADDR ? 8'h80 :
          state == LINE2_ADDR ? 8'hC0 : 8'h00;
    nxt = state == CLEAR      ? CLEAR_WAIT :
          state == LINE1_ADDR ? LINE1_DATA :
          state == LINE1_DATA ? (char_idx == 5'd15 ? LINE2_ADDR : LINE1_DATA) :
          state == LINE2_ADDR ? LINE2_DATA :
          state == LINE2_DATA ? (char_idx == 5'd31 ? LINE1_ADDR : LINE2_DATA) :
          state < CLEAR       ? state + 4'd1 : POWER_WAIT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div <= '0;
    else div <= tick ? '0 : div + 16'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= POWER_WAIT;
      phase      <= '0;
      cnt        <= '0;
      char_idx   <= '0;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        if (state == POWER_WAIT) begin
          cnt   <= cnt == 16'(POWER_TICKS - 1) ? '0 : cnt + 16'd1;
          state <= cnt == 16'(POWER_TICKS - 1) ? FUNC_SET : state;
        end else if (state == CLEAR_WAIT) begin
          cnt <= cnt == 16'(CLEAR_TICKS - 1) ? '0 : cnt + 16'd1;
          if (cnt == 16'(CLEAR_TICKS - 1)) begin
            state     <= LINE1_ADDR;
            init_done <= 1'b1;
          end
        end else if (phase == 2'd0) begin
          // char_data is sampled only here, so later upstream changes cannot disturb the write
          lcd_rs   <= is_data;
          lcd_data <= is_data ? char_data : cmd;
          phase    <= 2'd1;
        end else if (phase == 2'd1) begin
          lcd_e <= 1'b1;
          phase <= 2'd2;
        end else begin
          lcd_e <= 1'b0;
          phase <= 2'd0;
          state <= nxt;
          // request the next character one tick ahead of its phase-0 sample; idx 31 wraps to 0
          if (state == LINE1_ADDR) char_idx <= 5'd0;
          else if (state == LINE2_ADDR) char_idx <= 5'd16;
          else if (state == LINE2_DATA || (state == LINE1_DATA && char_idx != 5'd15)) char_idx <= char_idx + 5'd1;
          if (state == LINE2_DATA && char_idx == 5'd31) frame_done <= 1'b1;
        end
      end
    end
  end
endmodule
